max_scan_master: RTL and testbench

- Bus initiator for the data memory port: scans a block of words, finds the maximum value and its element index, then writes both results back to the memory's fixed result words.
- Sits beside the processor as a memory master; the top-level mux grants it the port while busy=1.
- Memory reads are combinational: rdata is valid in the same cycle as adr/rd. Memory writes commit on posedge clk.

---
 rtl/max_scan_if.sv | 26 ++
 rtl/max_scan_master.sv | 150 +++++++++++++++
 tb/tb_max_scan_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_scan_if.sv
// Handshake and memory-port bundle between the max-scan bus master and its
// surroundings (requester, memory mux, result consumers).
interface max_scan_if;
  logic        start;
  logic [31:0] base_adr;
  logic [31:0] count;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] max_out;
  logic [31:0] idx_out;

  modport master (
    input  start, base_adr, count, mem_rdata,
    output mem_adr, mem_wdata, mem_rd, mem_wr, busy, done, max_out, idx_out
  );

  modport slave (
    output start, base_adr, count, mem_rdata,
    input  mem_adr, mem_wdata, mem_rd, mem_wr, busy, done, max_out, idx_out
  );
endinterface

// File: rtl/max_scan_master.sv
// Memory master that scans count words starting at base_adr, finds the maximum
// and its element index, then writes both to fixed result words.
module max_scan_master #(
  parameter logic [31:0] ADDR_STEP  = 32'd4,
  parameter logic [31:0] MAX_ADR    = 32'd2000,
  parameter logic [31:0] IDX_ADR    = 32'd2004,
  parameter bit          SIGNED_CMP = 1'b1
) (
  input logic        clk,
  input logic        rst,
  max_scan_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WR_MAX = 3'd2,
    ST_WR_IDX = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] count_r;
  logic [31:0] i_r;
  logic [31:0] best_val_r;
  logic [31:0] best_idx_r;
  logic [31:0] mem_adr_r;
  logic [31:0] mem_wdata_r;
  logic        mem_rd_r;
  logic        mem_wr_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] max_out_r;
  logic [31:0] idx_out_r;

  logic        gt_s;
  logic        take_s;
  logic        last_s;
  logic [31:0] nxt_val_s;
  logic [31:0] nxt_idx_s;

  // Running-maximum candidate for the element currently on the read port
  always_comb begin
    if (SIGNED_CMP) begin
      gt_s = $signed(bus.mem_rdata) > $signed(best_val_r);
    end else begin
      gt_s = bus.mem_rdata > best_val_r;
    end
    take_s    = (i_r == 32'd0) || gt_s;
    last_s    = (i_r == (count_r - 32'd1));
    nxt_val_s = take_s ? bus.mem_rdata : best_val_r;
    nxt_idx_s = take_s ? i_r : best_idx_r;
  end

  // Scan FSM; every bus output is registered and set up for the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= 32'd0;
      i_r         <= 32'd0;
      best_val_r  <= 32'd0;
      best_idx_r  <= 32'd0;
      mem_adr_r   <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      max_out_r   <= 32'd0;
      idx_out_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            count_r    <= bus.count;
            i_r        <= 32'd0;
            best_val_r <= 32'd0;
            best_idx_r <= 32'd0;
            if (bus.count != 32'd0) begin
              state_r   <= ST_READ;
              mem_rd_r  <= 1'b1;
              mem_adr_r <= bus.base_adr;
              busy_r    <= 1'b1;
            end else begin
              // Empty block: report a zero result without touching memory
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              max_out_r <= 32'd0;
              idx_out_r <= 32'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          best_val_r <= nxt_val_s;
          best_idx_r <= nxt_idx_s;
          if (last_s) begin
            state_r     <= ST_WR_MAX;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b1;
            mem_adr_r   <= MAX_ADR;
            mem_wdata_r <= nxt_val_s;
          end else begin
            i_r       <= i_r + 32'd1;
            mem_adr_r <= mem_adr_r + ADDR_STEP;
          end
        end
        ST_WR_MAX: begin
          state_r     <= ST_WR_IDX;
          mem_adr_r   <= IDX_ADR;
          mem_wdata_r <= best_idx_r;
        end
        ST_WR_IDX: begin
          state_r     <= ST_DONE;
          mem_wr_r    <= 1'b0;
          mem_adr_r   <= 32'd0;
          mem_wdata_r <= 32'd0;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          max_out_r   <= best_val_r;
          idx_out_r   <= best_idx_r;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_adr_r   <= 32'd0;
          mem_wdata_r <= 32'd0;
          mem_rd_r    <= 1'b0;
          mem_wr_r    <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_adr   = mem_adr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.max_out   = max_out_r;
  assign bus.idx_out   = idx_out_r;

endmodule

// File: tb/tb_max_scan_master.sv
// Bench for max_scan_master: a signed and an unsigned instance scan the same
// random memory image and are compared against an array-scan reference.
module tb_max_scan_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_d;
  logic [31:0] base_d;
  logic [31:0] count_d;
  logic        load_img;
  logic        clr_obs;
  logic [31:0] exp_base;
  int          s_edge;
  int          edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] img [1024];

  logic [31:0] o_max [2];
  logic [31:0] o_idx [2];
  logic [31:0] o_adr [2];
  logic [31:0] o_wdata [2];
  logic        o_rd [2];
  logic        o_wr [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic [31:0] o_rd_cnt [2];
  logic [31:0] o_rd_bad [2];
  logic [31:0] o_wr_cnt [2];
  logic [31:0] o_wr_adr0 [2];
  logic [31:0] o_wr_dat0 [2];
  logic [31:0] o_wr_adr1 [2];
  logic [31:0] o_wr_dat1 [2];
  logic [31:0] o_proto_bad [2];
  logic [31:0] o_busy_cnt [2];
  logic [31:0] o_done_cnt [2];
  logic [31:0] o_done_cyc [2];
  logic [31:0] o_mem500 [2];
  logic [31:0] o_mem501 [2];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    max_scan_if bus_if ();
    logic [31:0] mem [1024];
    logic [31:0] rd_cnt, rd_bad, wr_cnt, proto_bad, busy_cnt, done_cnt, done_cyc;
    logic [31:0] wr_adr [2];
    logic [31:0] wr_dat [2];

    max_scan_master #(.SIGNED_CMP((g == 0) ? 1'b1 : 1'b0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.master)
    );

    assign bus_if.start     = start_d;
    assign bus_if.base_adr  = base_d;
    assign bus_if.count     = count_d;
    assign bus_if.mem_rdata = bus_if.mem_rd ? mem[bus_if.mem_adr[11:2]] : 32'd0;

    always @(posedge clk) begin
      if (load_img) begin
        for (int k = 0; k < 1024; k++) mem[k] <= img[k];
      end else if (bus_if.mem_wr) begin
        mem[bus_if.mem_adr[11:2]] <= bus_if.mem_wdata;
      end
    end

    always @(negedge clk) begin
      if (clr_obs) begin
        rd_cnt <= 32'd0; rd_bad <= 32'd0; wr_cnt <= 32'd0; proto_bad <= 32'd0;
        busy_cnt <= 32'd0; done_cnt <= 32'd0; done_cyc <= 32'd0;
        wr_adr[0] <= 32'd0; wr_adr[1] <= 32'd0; wr_dat[0] <= 32'd0; wr_dat[1] <= 32'd0;
      end else begin
        if (bus_if.mem_rd) begin
          if (bus_if.mem_adr !== exp_base + rd_cnt * 32'd4) rd_bad <= rd_bad + 32'd1;
          rd_cnt <= rd_cnt + 32'd1;
        end
        if (bus_if.mem_wr) begin
          if (wr_cnt < 32'd2) begin
            wr_adr[wr_cnt[0]] <= bus_if.mem_adr;
            wr_dat[wr_cnt[0]] <= bus_if.mem_wdata;
          end
          wr_cnt <= wr_cnt + 32'd1;
        end
        if ((bus_if.mem_rd && bus_if.mem_wr) ||
            (!bus_if.mem_rd && !bus_if.mem_wr && (bus_if.mem_adr != 32'd0 || bus_if.mem_wdata != 32'd0)))
          proto_bad <= proto_bad + 32'd1;
        if (bus_if.busy) busy_cnt <= busy_cnt + 32'd1;
        if (bus_if.done) begin
          if (done_cnt == 32'd0) done_cyc <= 32'(edge_cnt - s_edge);
          done_cnt <= done_cnt + 32'd1;
        end
      end
    end

    assign o_max[g] = bus_if.max_out;      assign o_idx[g] = bus_if.idx_out;
    assign o_adr[g] = bus_if.mem_adr;      assign o_wdata[g] = bus_if.mem_wdata;
    assign o_rd[g] = bus_if.mem_rd;        assign o_wr[g] = bus_if.mem_wr;
    assign o_busy[g] = bus_if.busy;        assign o_done[g] = bus_if.done;
    assign o_rd_cnt[g] = rd_cnt;           assign o_rd_bad[g] = rd_bad;
    assign o_wr_cnt[g] = wr_cnt;           assign o_proto_bad[g] = proto_bad;
    assign o_wr_adr0[g] = wr_adr[0];       assign o_wr_dat0[g] = wr_dat[0];
    assign o_wr_adr1[g] = wr_adr[1];       assign o_wr_dat1[g] = wr_dat[1];
    assign o_busy_cnt[g] = busy_cnt;       assign o_done_cnt[g] = done_cnt;
    assign o_done_cyc[g] = done_cyc;
    assign o_mem500[g] = mem[500];         assign o_mem501[g] = mem[501];
  end

  // Reference: plain scan over the word image, first strict maximum wins
  function automatic void ref_scan(input logic [31:0] base, input logic [31:0] cnt,
                                   input bit sgn, output logic [31:0] mx, output logic [31:0] ix);
    logic [31:0] a, v;
    bit better;
    mx = 32'd0; ix = 32'd0;
    for (int k = 0; k < int'(cnt); k++) begin
      a = base + 32'(k) * 32'd4;
      v = img[a[11:2]];
      better = sgn ? ($signed(v) > $signed(mx)) : (v > mx);
      if (k == 0 || better) begin mx = v; ix = 32'(k); end
    end
  endfunction

  task automatic load_image();
    @(posedge clk); #1 load_img = 1'b1;
    @(posedge clk); #1 load_img = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 1024; k++) img[k] = $urandom;
  endtask

  task automatic clear_obs();
    @(posedge clk); #1 clr_obs = 1'b1;
    @(posedge clk); #1 clr_obs = 1'b0;
  endtask

  task automatic scan_and_check(input string nm, input logic [31:0] base,
                                input logic [31:0] cnt, input int restart_at);
    logic [31:0] mx [2];
    logic [31:0] ix [2];
    logic [31:0] e500, e501, e_busy, e_wr, e_cyc;
    ref_scan(base, cnt, 1'b1, mx[0], ix[0]);
    ref_scan(base, cnt, 1'b0, mx[1], ix[1]);
    clear_obs();
    exp_base = base; base_d = base; count_d = cnt; start_d = 1'b1; s_edge = edge_cnt;
    for (int c = 1; c <= int'(cnt) + 6; c++) begin
      @(posedge clk); #1;
      start_d = (c == restart_at);
      base_d  = start_d ? base + 32'd64 : $urandom;
      count_d = start_d ? 32'd2 : $urandom;
    end
    start_d = 1'b0;
    @(negedge clk); #1;
    e_cyc  = (cnt == 32'd0) ? 32'd1 : cnt + 32'd3;
    e_busy = (cnt == 32'd0) ? 32'd0 : cnt + 32'd2;
    e_wr   = (cnt == 32'd0) ? 32'd0 : 32'd2;
    for (int g = 0; g < 2; g++) begin
      e500 = (cnt == 32'd0) ? img[500] : mx[g];
      e501 = (cnt == 32'd0) ? img[501] : ix[g];
      checks += 12;
      if (o_done_cnt[g] !== 32'd1) begin errors++; $display("FAIL %s[%0d] done_count: got %0d expected 1", nm, g, o_done_cnt[g]); end
      if (o_done_cyc[g] !== e_cyc) begin errors++; $display("FAIL %s[%0d] done_cycle: got %0d expected %0d", nm, g, o_done_cyc[g], e_cyc); end
      if (o_rd_cnt[g] !== cnt) begin errors++; $display("FAIL %s[%0d] read_count: got %0d expected %0d", nm, g, o_rd_cnt[g], cnt); end
      if (o_rd_bad[g] !== 32'd0) begin errors++; $display("FAIL %s[%0d] read_addr: got %0d bad addresses expected 0", nm, g, o_rd_bad[g]); end
      if (o_busy_cnt[g] !== e_busy) begin errors++; $display("FAIL %s[%0d] busy_cycles: got %0d expected %0d", nm, g, o_busy_cnt[g], e_busy); end
      if (o_wr_cnt[g] !== e_wr) begin errors++; $display("FAIL %s[%0d] write_count: got %0d expected %0d", nm, g, o_wr_cnt[g], e_wr); end
      if (o_proto_bad[g] !== 32'd0) begin errors++; $display("FAIL %s[%0d] bus_idle_rules: got %0d violations expected 0", nm, g, o_proto_bad[g]); end
      if (o_max[g] !== mx[g]) begin errors++; $display("FAIL %s[%0d] max_out: got %h expected %h", nm, g, o_max[g], mx[g]); end
      if (o_idx[g] !== ix[g]) begin errors++; $display("FAIL %s[%0d] idx_out: got %0d expected %0d", nm, g, o_idx[g], ix[g]); end
      if (o_mem500[g] !== e500) begin errors++; $display("FAIL %s[%0d] mem2000: got %h expected %h", nm, g, o_mem500[g], e500); end
      if (o_mem501[g] !== e501) begin errors++; $display("FAIL %s[%0d] mem2004: got %h expected %h", nm, g, o_mem501[g], e501); end
      if ({o_wr_adr0[g], o_wr_dat0[g], o_wr_adr1[g], o_wr_dat1[g]} !==
          ((cnt == 32'd0) ? 128'd0 : {32'd2000, mx[g], 32'd2004, ix[g]})) begin
        errors++;
        $display("FAIL %s[%0d] write_seq: got %0d:%h %0d:%h", nm, g, o_wr_adr0[g], o_wr_dat0[g], o_wr_adr1[g], o_wr_dat1[g]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({o_rd[g], o_wr[g], o_adr[g], o_wdata[g], o_busy[g], o_done[g], o_max[g], o_idx[g]} !== 132'd0) begin
        errors++;
        $display("FAIL %s[%0d] outputs: got rd=%b wr=%b adr=%h wd=%h busy=%b done=%b max=%h idx=%h expected all zero",
                 nm, g, o_rd[g], o_wr[g], o_adr[g], o_wdata[g], o_busy[g], o_done[g], o_max[g], o_idx[g]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_random();
    img[25] = 32'd5; img[26] = 32'd9; img[27] = 32'd3; img[28] = 32'd7;
    load_image();
    scan_and_check("basic", 32'd100, 32'd4, 0);
    checks += 2;
    if (o_max[0] !== 32'd9) begin errors++; $display("FAIL basic_const max_out: got %0d expected 9", o_max[0]); end
    if (o_idx[0] !== 32'd1) begin errors++; $display("FAIL basic_const idx_out: got %0d expected 1", o_idx[0]); end
  endtask

  task automatic test_signedness();
    fill_random();
    img[50] = 32'hFFFF_FFFF; img[51] = 32'hFFFF_FFFB; img[52] = 32'd2;
    load_image();
    scan_and_check("signedness", 32'd200, 32'd3, 0);
    checks += 2;
    if ({o_max[0], o_idx[0]} !== {32'd2, 32'd2}) begin errors++; $display("FAIL signed_const max/idx: got %h/%0d expected 2/2", o_max[0], o_idx[0]); end
    if ({o_max[1], o_idx[1]} !== {32'hFFFF_FFFF, 32'd0}) begin errors++; $display("FAIL unsigned_const max/idx: got %h/%0d expected ffffffff/0", o_max[1], o_idx[1]); end
  endtask

  task automatic test_ties();
    fill_random();
    img[75] = 32'd8; img[76] = 32'd8; img[77] = 32'd8;
    load_image();
    scan_and_check("ties", 32'd300, 32'd3, 0);
    checks++;
    if ({o_idx[0], o_mem501[0]} !== 64'd0) begin errors++; $display("FAIL ties_const idx/mem2004: got %0d/%0d expected 0/0", o_idx[0], o_mem501[0]); end
  endtask

  task automatic test_count_zero();
    fill_random();
    img[500] = 32'hDEAD_BEEF;
    load_image();
    scan_and_check("count_zero", 32'd400, 32'd0, 0);
  endtask

  task automatic test_wrap_and_overlap();
    fill_random();
    load_image();
    scan_and_check("wrap", 32'hFFFF_FFF8, 32'd4, 0);
    fill_random();
    load_image();
    scan_and_check("overlap", 32'd1996, 32'd4, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      fill_random();
      for (int k = 0; k < 1024; k++) if ($urandom_range(0, 3) == 0) img[k] = $urandom_range(0, 3);
      load_image();
      scan_and_check("random", 32'($urandom_range(0, 1023)) * 32'd4, 32'($urandom_range(1, 24)), 0);
    end
  endtask

  task automatic test_back_to_back_start();
    fill_random();
    load_image();
    scan_and_check("start_busy", 32'd600, 32'd3, 2);
  endtask

  task automatic test_reset_mid();
    fill_random();
    load_image();
    clear_obs();
    exp_base = 32'd100; base_d = 32'd100; count_d = 32'd5; start_d = 1'b1; s_edge = edge_cnt;
    @(posedge clk); #1 start_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({o_rd[g], o_adr[g]} !== {1'b1, 32'd108}) begin errors++; $display("FAIL reset_mid[%0d] elem2_read: got rd=%b adr=%0d expected 1/108", g, o_rd[g], o_adr[g]); end
    end
    rst = 1'b1;
    #1 check_idle_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      checks += 2;
      if ({o_wr_cnt[g], o_done_cnt[g]} !== 64'd0) begin errors++; $display("FAIL reset_mid[%0d] writes/done: got %0d/%0d expected 0/0", g, o_wr_cnt[g], o_done_cnt[g]); end
      if ({o_mem500[g], o_mem501[g]} !== {img[500], img[501]}) begin errors++; $display("FAIL reset_mid[%0d] result_words: got %h/%h expected %h/%h", g, o_mem500[g], o_mem501[g], img[500], img[501]); end
    end
    scan_and_check("after_reset", 32'd100, 32'd5, 0);
  endtask

  initial begin
    rst = 1'b1; start_d = 1'b0; base_d = 32'd0; count_d = 32'd0;
    load_img = 1'b0; clr_obs = 1'b0; exp_base = 32'd0; s_edge = 0;
    test_reset();
    test_basic();
    test_signedness();
    test_ties();
    test_count_zero();
    test_wrap_and_overlap();
    test_random();
    test_back_to_back_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
